mcu_bridge_ctrl: RTL and testbench
==================================

# mcu_bridge_ctrl

MCU-side sequencer for the 6502-to-MCU bus interface. It buffers outbound bytes and drives the TX latch data and `TX_LOAD` strobe. It drains the RX latch and returns `RX_ACK`. It synchronizes the asynchronous `DATA_TAKEN`/`DATA_WRITTEN` handshake flags into the MCU clock domain. It sits directly between the MCU fabric and the 6502-side handshake flip-flops, and owns the startup `RX_ACK` pulse that arms `RX_READY`.

## Interface
Parameters:
- `DEPTH`, 16: entries per FIFO; power of 2, ≥2.
- `SETTLE`, 2: cycles data is held stable before `TX_LOAD` rises, and before RX capture.
- `ACK_PULSE`, 4: high width in cycles of `TX_LOAD` and `RX_ACK`; ≥3.
- `TIMEOUT_CYCLES`, 1000000: stall threshold (only with the macro).

Ports (`LW` = $clog2(DEPTH)+1):
- Clocking and reset (already decided): one clock, `CLK`; reset `RST`, synchronous, active-high.
- `CLK`  in  1  MCU-domain clock.
- `RST`  in  1  synchronous active-high reset.
- `TX_DATA_IN`  in  8  byte to send to the 6502.
- `TX_VALID`  in  1  push request; accepted when `TX_READY`=1.
- `TX_READY`  out  1  TX FIFO not full.
- `TX_LEVEL`  out  LW  TX FIFO occupancy.
- `RX_DATA_OUT`  out  8  RX FIFO head (show-ahead).
- `RX_VALID`  out  1  RX FIFO not empty.
- `RX_POP`  in  1  pop head; ignored when `RX_VALID`=0.
- `RX_LEVEL`  out  LW  RX FIFO occupancy.
- `TX_LATCH_D`  out  8  data to TX latch.
- `TX_LOAD`  out  1  TX latch strobe; its rising edge sets `TX_AVAIL`.
- `DATA_TAKEN`  in  1  async; CPU has read the TX byte.
- `RX_LATCH_Q`  in  8  RX latch contents.
- `RX_ACK`  out  1  ack pulse; sets `RX_READY`, clears `DATA_WRITTEN`.
- `DATA_WRITTEN`  in  1  async; CPU has written an RX byte.
- `TX_STALL`  out  1  TX byte not taken within timeout.

## Operation
- Synchronizers: `DATA_TAKEN` and `DATA_WRITTEN` each pass through a 2-FF synchronizer, giving `dt_s`/`dw_s`. No other logic samples the raw inputs.
- TX FSM:
  - T_IDLE: if the TX FIFO is non-empty, pop it, load the head into `TX_LATCH_D`, and go to T_SETUP.
  - T_SETUP: hold for `SETTLE` cycles, then go to T_PULSE.
  - T_PULSE: `TX_LOAD`=1 for `ACK_PULSE` cycles, then go to T_WAIT.
  - T_WAIT: when `dt_s`=1, go to T_IDLE.
  - `ACK_PULSE`≥3 guarantees `dt_s` has seen the clear caused by `TX_LOAD` before T_WAIT is entered.
- RX FSM:
  - R_INIT (entered on reset exit): `RX_ACK`=1 for `ACK_PULSE` cycles, then go to R_IDLE.
  - R_IDLE: when `dw_s`=1, go to R_SETTLE.
  - R_SETTLE: wait `SETTLE` cycles, capture `RX_LATCH_Q`, then go to R_PUSH.
  - R_PUSH: if the RX FIFO is not full, push the captured byte and go to R_ACK. Otherwise stay; no ack is issued, so `RX_READY` stays 0 and the 6502 is back-pressured.
  - R_ACK: `RX_ACK`=1 for `ACK_PULSE` cycles, then go to R_DRAIN.
  - R_DRAIN: when `dw_s`=0, go to R_IDLE.
- FIFOs are circular, with `LW`-bit pointers and wrap-around.
  - TX: a push while full is impossible because `TX_READY`=0.
  - RX: `RX_POP` while empty is ignored.
  - "Full" is evaluated on registered state, so a same-cycle pop does not permit a push when full.
  - A simultaneous push and pop when neither full nor empty leaves the level unchanged.
- Reset:
  - During `RST`, all outputs are 0: `TX_LATCH_D`=0x00, FIFOs empty, `TX_READY`=0, `TX_STALL`=0.
  - The cycle after release: `TX_READY`=1, T_IDLE, R_INIT (`RX_ACK` goes to 1).
  - Reset mid-pulse aborts it (the strobe drops the next edge). Buffered bytes are discarded.

## Timing
- TX latency: a push into an empty FIFO with T_IDLE at edge 0 gives `TX_LATCH_D` valid at edge 1. `TX_LOAD` is high from edge 1+`SETTLE` through edge `SETTLE`+`ACK_PULSE` (edge 3 to edge 6 at defaults).
- Back-to-back TX: the next load starts at the earliest 1 cycle after `dt_s` rises (≥3 cycles after raw `DATA_TAKEN`).
- RX latency: raw `DATA_WRITTEN` rising gives `dw_s` 2 cycles later. Capture follows `SETTLE` cycles after that, the push 1 cycle after capture, then `RX_ACK` for `ACK_PULSE` cycles.
- `RX_VALID` and `RX_DATA_OUT` update the cycle after a push; `TX_LEVEL`/`RX_LEVEL` update the cycle after the event.

## Configuration
- `MCU_BRIDGE_TIMEOUT_EN` defined:
  - A 32-bit counter runs in T_WAIT and clears on every entry to T_WAIT.
  - On reaching `TIMEOUT_CYCLES`, `TX_STALL`=1 until T_WAIT exits or `RST`.
  - The FSM is not altered; it keeps waiting.
- Undefined: no counter; `TX_STALL` tied to 0.

## Test plan
- Reset release: `RX_ACK` is high exactly 4 cycles starting the cycle after `RST` drops; `TX_READY`=1; both levels are 0.
- Push 0xA5 with `DATA_TAKEN` stuck 0: `TX_LATCH_D`=0xA5 at edge 1, `TX_LOAD` high for edges 3–6, then the FSM holds in T_WAIT. Pulse `DATA_TAKEN`: the next byte 0x5A loads ≥3 cycles later.
- Fill the TX FIFO with 16 bytes while the link is blocked: `TX_READY`=0, `TX_LEVEL`=16, and the wrap order is preserved through 40 bytes total.
- Set `RX_LATCH_Q`=0x3C and raise `DATA_WRITTEN`: `RX_DATA_OUT`=0x3C with `RX_VALID`=1, then a 4-cycle `RX_ACK`. Drop `DATA_WRITTEN`: the FSM returns to R_IDLE.
- RX FIFO full (16 entries) and a 17th write arrives: no `RX_ACK` is issued. One `RX_POP` leads to the push and the ack, with `RX_LEVEL` returning to 16.
- With `MCU_BRIDGE_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100: `TX_STALL` rises after 100 cycles in T_WAIT and clears the cycle after `dt_s`=1.

Source files
------------

// File: rtl/mcu_bridge_ctrl.sv
// MCU-side sequencer for the 6502 bus bridge: TX/RX byte FIFOs, latch strobes, handshake sync.
// Optional TX stall detection is enabled with `define MCU_BRIDGE_TIMEOUT_EN.
module mcu_bridge_ctrl #(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned SETTLE         = 2,
  parameter int unsigned ACK_PULSE      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [7:0]                TX_DATA_IN,
  input  logic                      TX_VALID,
  output logic                      TX_READY,
  output logic [$clog2(DEPTH):0]    TX_LEVEL,
  output logic [7:0]                RX_DATA_OUT,
  output logic                      RX_VALID,
  input  logic                      RX_POP,
  output logic [$clog2(DEPTH):0]    RX_LEVEL,
  output logic [7:0]                TX_LATCH_D,
  output logic                      TX_LOAD,
  input  logic                      DATA_TAKEN,
  input  logic [7:0]                RX_LATCH_Q,
  output logic                      RX_ACK,
  input  logic                      DATA_WRITTEN,
  output logic                      TX_STALL
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(SETTLE + ACK_PULSE + 1);

  typedef enum logic [1:0] {T_IDLE, T_SETUP, T_PULSE, T_WAIT} tx_state_t;
  typedef enum logic [2:0] {R_INIT, R_IDLE, R_SETTLE, R_PUSH, R_ACK, R_DRAIN} rx_state_t;

  logic r_dt_meta, r_dt_s, r_dw_meta, r_dw_s;

  logic [7:0]    r_tx_mem [DEPTH];
  logic [LW-1:0] r_tx_wr, r_tx_rd, r_tx_level, w_tx_level_nxt;
  logic          r_tx_ready, w_tx_push, w_tx_pop;

  logic [7:0]    r_rx_mem [DEPTH];
  logic [LW-1:0] r_rx_wr, r_rx_rd, r_rx_level, w_rx_level_nxt, w_rx_rd_nxt;
  logic [7:0]    r_rx_head, w_rx_head_nxt;
  logic          r_rx_valid, w_rx_push, w_rx_pop;

  tx_state_t     r_tx_state, w_tx_state_nxt;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [7:0]    r_tx_d, w_tx_d_nxt;
  logic          r_tx_load, w_tx_load_nxt;

  rx_state_t     r_rx_state, w_rx_state_nxt;
  logic [CW-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [7:0]    r_rx_cap, w_rx_cap_nxt;
  logic          r_rx_ack, w_rx_ack_nxt;

  // Two-flop synchronizers for the asynchronous handshake flags
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dt_meta <= 1'b0;
      r_dt_s    <= 1'b0;
      r_dw_meta <= 1'b0;
      r_dw_s    <= 1'b0;
    end else begin
      r_dt_meta <= DATA_TAKEN;
      r_dt_s    <= r_dt_meta;
      r_dw_meta <= DATA_WRITTEN;
      r_dw_s    <= r_dw_meta;
    end
  end

  assign w_tx_push      = TX_VALID && r_tx_ready;
  assign w_tx_level_nxt = r_tx_level + LW'(w_tx_push) - LW'(w_tx_pop);

  always_ff @(posedge CLK) begin
    if (w_tx_push) r_tx_mem[r_tx_wr[AW-1:0]] <= TX_DATA_IN;
    if (w_rx_push) r_rx_mem[r_rx_wr[AW-1:0]] <= r_rx_cap;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tx_wr    <= '0;
      r_tx_rd    <= '0;
      r_tx_level <= '0;
      r_tx_ready <= 1'b0;
    end else begin
      r_tx_wr    <= r_tx_wr + LW'(w_tx_push);
      r_tx_rd    <= r_tx_rd + LW'(w_tx_pop);
      r_tx_level <= w_tx_level_nxt;
      r_tx_ready <= (w_tx_level_nxt != LW'(DEPTH));
    end
  end

  // Show-ahead head: bypass the pushed byte when the FIFO would otherwise be empty
  assign w_rx_pop       = RX_POP && r_rx_valid;
  assign w_rx_level_nxt = r_rx_level + LW'(w_rx_push) - LW'(w_rx_pop);
  assign w_rx_rd_nxt    = r_rx_rd + LW'(w_rx_pop);

  always_comb begin
    w_rx_head_nxt = r_rx_mem[w_rx_rd_nxt[AW-1:0]];
    if (w_rx_push && (r_rx_wr == w_rx_rd_nxt)) w_rx_head_nxt = r_rx_cap;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rx_wr    <= '0;
      r_rx_rd    <= '0;
      r_rx_level <= '0;
      r_rx_valid <= 1'b0;
      r_rx_head  <= 8'h00;
    end else begin
      r_rx_wr    <= r_rx_wr + LW'(w_rx_push);
      r_rx_rd    <= w_rx_rd_nxt;
      r_rx_level <= w_rx_level_nxt;
      r_rx_valid <= (w_rx_level_nxt != '0);
      r_rx_head  <= w_rx_head_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tx_state <= T_IDLE;
      r_tx_cnt   <= '0;
      r_tx_d     <= 8'h00;
      r_tx_load  <= 1'b0;
      r_rx_state <= R_INIT;
      r_rx_cnt   <= '0;
      r_rx_cap   <= 8'h00;
      r_rx_ack   <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_d     <= w_tx_d_nxt;
      r_tx_load  <= w_tx_load_nxt;
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_cap   <= w_rx_cap_nxt;
      r_rx_ack   <= w_rx_ack_nxt;
    end
  end

  // TX sequencer: load latch, settle, strobe, wait for CPU to take the byte
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_d_nxt     = r_tx_d;
    w_tx_load_nxt  = 1'b0;
    w_tx_pop       = 1'b0;
    case (r_tx_state)
      T_IDLE: begin
        if (r_tx_level != '0) begin
          w_tx_pop       = 1'b1;
          w_tx_d_nxt     = r_tx_mem[r_tx_rd[AW-1:0]];
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = T_SETUP;
        end
      end
      T_SETUP: begin
        if (r_tx_cnt == CW'(SETTLE - 1)) begin
          w_tx_cnt_nxt   = '0;
          w_tx_load_nxt  = 1'b1;
          w_tx_state_nxt = T_PULSE;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + 1'b1;
        end
      end
      T_PULSE: begin
        if (r_tx_cnt == CW'(ACK_PULSE - 1)) begin
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = T_WAIT;
        end else begin
          w_tx_load_nxt = 1'b1;
          w_tx_cnt_nxt  = r_tx_cnt + 1'b1;
        end
      end
      T_WAIT:  if (r_dt_s) w_tx_state_nxt = T_IDLE;
      default: w_tx_state_nxt = T_IDLE;
    endcase
  end

  // RX sequencer: startup ack, then settle/capture/push/ack per written byte
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_cap_nxt   = r_rx_cap;
    w_rx_ack_nxt   = 1'b0;
    w_rx_push      = 1'b0;
    case (r_rx_state)
      R_INIT: begin
        if (r_rx_cnt == CW'(ACK_PULSE)) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = R_IDLE;
        end else begin
          w_rx_ack_nxt = 1'b1;
          w_rx_cnt_nxt = r_rx_cnt + 1'b1;
        end
      end
      R_IDLE: begin
        if (r_dw_s) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = R_SETTLE;
        end
      end
      R_SETTLE: begin
        if (r_rx_cnt == CW'(SETTLE - 1)) begin
          w_rx_cap_nxt   = RX_LATCH_Q;
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = R_PUSH;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 1'b1;
        end
      end
      R_PUSH: begin
        if (r_rx_level != LW'(DEPTH)) begin
          w_rx_push      = 1'b1;
          w_rx_ack_nxt   = 1'b1;
          w_rx_state_nxt = R_ACK;
        end
      end
      R_ACK: begin
        if (r_rx_cnt == CW'(ACK_PULSE - 1)) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = R_DRAIN;
        end else begin
          w_rx_ack_nxt = 1'b1;
          w_rx_cnt_nxt = r_rx_cnt + 1'b1;
        end
      end
      R_DRAIN: if (!r_dw_s) w_rx_state_nxt = R_IDLE;
      default: w_rx_state_nxt = R_IDLE;
    endcase
  end

`ifdef MCU_BRIDGE_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  logic        r_tx_stall;

  // Counter is held at zero outside T_WAIT, so every entry starts fresh
  always_ff @(posedge CLK) begin
    if (RST || (r_tx_state != T_WAIT)) begin
      r_to_cnt   <= '0;
      r_tx_stall <= 1'b0;
    end else if (w_tx_state_nxt != T_WAIT) begin
      r_tx_stall <= 1'b0;
    end else if (r_to_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
      r_tx_stall <= 1'b1;
    end else begin
      r_to_cnt <= r_to_cnt + 32'd1;
    end
  end

  assign TX_STALL = r_tx_stall;
`else
  logic w_unused_to;
  assign w_unused_to = ^32'(TIMEOUT_CYCLES);
  assign TX_STALL    = 1'b0;
`endif

  assign TX_READY    = r_tx_ready;
  assign TX_LEVEL    = r_tx_level;
  assign RX_DATA_OUT = r_rx_head;
  assign RX_VALID    = r_rx_valid;
  assign RX_LEVEL    = r_rx_level;
  assign TX_LATCH_D  = r_tx_d;
  assign TX_LOAD     = r_tx_load;
  assign RX_ACK      = r_rx_ack;
endmodule

// File: tb/tb_mcu_bridge_ctrl.sv
// Scoreboard bench for mcu_bridge_ctrl: directed TX/RX traffic, queued expectations, negedge monitor.
module tb_mcu_bridge_ctrl;
  localparam int unsigned LW = 5;

  logic          CLK = 1'b0;
  logic          RST;
  logic [7:0]    TX_DATA_IN;
  logic          TX_VALID;
  logic          TX_READY;
  logic [LW-1:0] TX_LEVEL;
  logic [7:0]    RX_DATA_OUT;
  logic          RX_VALID;
  logic          RX_POP;
  logic [LW-1:0] RX_LEVEL;
  logic [7:0]    TX_LATCH_D;
  logic          TX_LOAD;
  logic          DATA_TAKEN;
  logic [7:0]    RX_LATCH_Q;
  logic          RX_ACK;
  logic          DATA_WRITTEN;
  logic          TX_STALL;

  mcu_bridge_ctrl #(.DEPTH(16), .SETTLE(2), .ACK_PULSE(4), .TIMEOUT_CYCLES(100)) dut (
    .CLK(CLK), .RST(RST),
    .TX_DATA_IN(TX_DATA_IN), .TX_VALID(TX_VALID), .TX_READY(TX_READY), .TX_LEVEL(TX_LEVEL),
    .RX_DATA_OUT(RX_DATA_OUT), .RX_VALID(RX_VALID), .RX_POP(RX_POP), .RX_LEVEL(RX_LEVEL),
    .TX_LATCH_D(TX_LATCH_D), .TX_LOAD(TX_LOAD), .DATA_TAKEN(DATA_TAKEN),
    .RX_LATCH_Q(RX_LATCH_Q), .RX_ACK(RX_ACK), .DATA_WRITTEN(DATA_WRITTEN), .TX_STALL(TX_STALL)
  );

  always #5 CLK = ~CLK;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] mon_exp;
  logic       prev_load = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: each TX strobe and each accepted RX pop is scored against the queues
  always @(negedge CLK) begin
    if (TX_LOAD && !prev_load) begin
      if (tx_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL tx_sb: unexpected load of 0x%0h", TX_LATCH_D);
      end else begin
        mon_exp = tx_q.pop_front();
        check("tx_sb", 32'(TX_LATCH_D), 32'(mon_exp));
      end
    end
    prev_load = TX_LOAD;
    if (RX_POP && RX_VALID) begin
      if (rx_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rx_sb: unexpected byte 0x%0h", RX_DATA_OUT);
      end else begin
        mon_exp = rx_q.pop_front();
        check("rx_sb", 32'(RX_DATA_OUT), 32'(mon_exp));
      end
    end
  end

  task automatic rx_write(input logic [7:0] b, output bit ok);
    int cyc;
    RX_LATCH_Q   = b;
    DATA_WRITTEN = 1'b1;
    rx_q.push_back(b);
    cyc = 0;
    while (!RX_ACK && cyc < 50) begin tick(); cyc++; end
    ok = RX_ACK;
    DATA_WRITTEN = 1'b0;
    cyc = 0;
    while (RX_ACK && cyc < 50) begin tick(); cyc++; end
    repeat (3) tick();
  endtask

  initial begin
    repeat (20000) @(posedge CLK);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    int  n;
    int  cyc;
    bit  ok;
    bit  seen;
    RST = 1'b1; TX_DATA_IN = 8'h00; TX_VALID = 1'b0; RX_POP = 1'b0;
    DATA_TAKEN = 1'b0; RX_LATCH_Q = 8'h00; DATA_WRITTEN = 1'b0;
    repeat (3) tick();
    check("rst_tx_ready", 32'(TX_READY), 0);
    check("rst_rx_ack", 32'(RX_ACK), 0);
    check("rst_latch", 32'(TX_LATCH_D), 0);
    check("rst_tx_level", 32'(TX_LEVEL), 0);
    check("rst_rx_level", 32'(RX_LEVEL), 0);
    check("rst_rx_valid", 32'(RX_VALID), 0);
    check("rst_stall", 32'(TX_STALL), 0);

    // Reset release: startup RX_ACK pulse
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("init_ack", 32'(RX_ACK), 32'(i < 4));
      if (i == 0) begin
        check("init_tx_ready", 32'(TX_READY), 1);
        check("init_tx_level", 32'(TX_LEVEL), 0);
        check("init_rx_level", 32'(RX_LEVEL), 0);
      end
    end

    // Single TX byte with DATA_TAKEN stuck low
    TX_DATA_IN = 8'hA5; TX_VALID = 1'b1; tx_q.push_back(8'hA5);
    tick();
    TX_VALID = 1'b0;
    check("tx_level_push", 32'(TX_LEVEL), 1);
    for (int e = 1; e <= 8; e++) begin
      tick();
      check("tx_load_win", 32'(TX_LOAD), 32'(e >= 3 && e <= 6));
      if (e == 1) check("tx_latch_e1", 32'(TX_LATCH_D), 32'h A5);
    end
    TX_DATA_IN = 8'h5A; TX_VALID = 1'b1; tx_q.push_back(8'h5A);
    tick();
    TX_VALID = 1'b0;
    repeat (10) tick();
    check("tx_wait_hold_load", 32'(TX_LOAD), 0);
    check("tx_wait_hold_level", 32'(TX_LEVEL), 1);
`ifndef MCU_BRIDGE_TIMEOUT_EN
    check("tx_no_stall", 32'(TX_STALL), 0);
`endif
    DATA_TAKEN = 1'b1;
    tick();
    DATA_TAKEN = 1'b0;
    check("tx_dt_j0", 32'(TX_LATCH_D), 32'hA5);
    tick();
    check("tx_dt_j1", 32'(TX_LATCH_D), 32'hA5);
    tick();
    check("tx_dt_j2", 32'(TX_LATCH_D), 32'hA5);
    tick();
    check("tx_dt_j3", 32'(TX_LATCH_D), 32'h5A);
    check("tx_dt_level", 32'(TX_LEVEL), 0);
    repeat (6) tick();

    // Fill TX FIFO while blocked, then drain with wrap through 40 bytes
    for (int i = 0; i < 16; i++) begin
      TX_DATA_IN = 8'(16 + i); TX_VALID = 1'b1; tx_q.push_back(8'(16 + i));
      tick();
    end
    TX_DATA_IN = 8'hEE;
    check("tx_full_ready", 32'(TX_READY), 0);
    check("tx_full_level", 32'(TX_LEVEL), 16);
    tick();
    check("tx_full_reject", 32'(TX_LEVEL), 16);
    TX_VALID = 1'b0;
    DATA_TAKEN = 1'b1;
    n = 16;
    cyc = 0;
    while ((n < 40 || tx_q.size() != 0) && cyc < 3000) begin
      if (n < 40 && TX_READY) begin
        TX_DATA_IN = 8'(16 + n); TX_VALID = 1'b1; tx_q.push_back(8'(16 + n));
        n++;
      end else begin
        TX_VALID = 1'b0;
      end
      tick();
      cyc++;
    end
    TX_VALID = 1'b0;
    check("tx_drain_in_time", 32'(cyc < 3000), 1);
    repeat (8) tick();
    DATA_TAKEN = 1'b0;
    repeat (3) tick();
    check("tx_drain_level", 32'(TX_LEVEL), 0);
    check("tx_drain_ready", 32'(TX_READY), 1);

    // Single RX byte with cycle-accurate ack window
    RX_LATCH_Q = 8'h3C; DATA_WRITTEN = 1'b1; rx_q.push_back(8'h3C);
    for (int k = 0; k < 12; k++) begin
      tick();
      check("rx_ack_win", 32'(RX_ACK), 32'(k >= 5 && k <= 8));
      check("rx_valid_win", 32'(RX_VALID), 32'(k >= 5));
      if (k == 5) begin
        check("rx_data", 32'(RX_DATA_OUT), 32'h3C);
        check("rx_level1", 32'(RX_LEVEL), 1);
      end
    end
    DATA_WRITTEN = 1'b0;
    repeat (4) tick();
    RX_POP = 1'b1;
    tick();
    RX_POP = 1'b0;
    check("rx_pop_valid", 32'(RX_VALID), 0);
    check("rx_pop_level", 32'(RX_LEVEL), 0);

    // RX FIFO full: 17th write is back-pressured until a pop
    for (int i = 0; i < 16; i++) begin
      rx_write(8'(8'hC0 + i), ok);
      check("rx_write_ack", 32'(ok), 1);
    end
    check("rx_full_level", 32'(RX_LEVEL), 16);
    check("rx_full_head", 32'(RX_DATA_OUT), 32'hC0);
    RX_LATCH_Q = 8'h77; DATA_WRITTEN = 1'b1; rx_q.push_back(8'h77);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (RX_ACK) seen = 1'b1;
    end
    RX_LATCH_Q = 8'h00;
    check("rx_full_noack", 32'(seen), 0);
    check("rx_full_level_hold", 32'(RX_LEVEL), 16);
    RX_POP = 1'b1;
    tick();
    RX_POP = 1'b0;
    check("rx_pop_full_level", 32'(RX_LEVEL), 15);
    cyc = 0;
    while (!RX_ACK && cyc < 20) begin tick(); cyc++; end
    check("rx_ack_after_pop", 32'(RX_ACK), 1);
    check("rx_level_refill", 32'(RX_LEVEL), 16);
    DATA_WRITTEN = 1'b0;
    repeat (8) tick();
    RX_POP = 1'b1;
    cyc = 0;
    while (RX_VALID && cyc < 40) begin tick(); cyc++; end
    RX_POP = 1'b0;
    check("rx_sb_empty", 32'(rx_q.size()), 0);
    check("rx_drain_level", 32'(RX_LEVEL), 0);

    // Reset in the middle of a strobe discards it and the buffered byte
    TX_DATA_IN = 8'h99; TX_VALID = 1'b1; tx_q.push_back(8'h99);
    tick();
    TX_DATA_IN = 8'h66;
    tick();
    TX_VALID = 1'b0;
    repeat (3) tick();
    check("mid_load_high", 32'(TX_LOAD), 1);
    check("mid_level", 32'(TX_LEVEL), 1);
    RST = 1'b1;
    tick();
    check("mid_rst_load", 32'(TX_LOAD), 0);
    check("mid_rst_level", 32'(TX_LEVEL), 0);
    check("mid_rst_latch", 32'(TX_LATCH_D), 0);
    RST = 1'b0;
    repeat (10) tick();
    check("mid_after_load", 32'(TX_LOAD), 0);
    check("mid_after_level", 32'(TX_LEVEL), 0);

`ifdef MCU_BRIDGE_TIMEOUT_EN
    // Stall flag after 100 cycles in T_WAIT
    TX_DATA_IN = 8'h42; TX_VALID = 1'b1; tx_q.push_back(8'h42);
    tick();
    TX_VALID = 1'b0;
    repeat (7) tick();
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (k == 99)  check("stall_pre", 32'(TX_STALL), 0);
      if (k == 100) check("stall_set", 32'(TX_STALL), 1);
    end
    DATA_TAKEN = 1'b1;
    tick();
    check("stall_hold_j0", 32'(TX_STALL), 1);
    tick();
    check("stall_hold_j1", 32'(TX_STALL), 1);
    tick();
    check("stall_clear", 32'(TX_STALL), 0);
    DATA_TAKEN = 1'b0;
    repeat (3) tick();
`else
    check("stall_tied", 32'(TX_STALL), 0);
`endif

    check("tx_sb_empty", 32'(tx_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
